// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framer/deframer pair: FSM states and the frame CRC-8.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SOF,
    ST_LEN,
    ST_PAY,
    ST_CRC
  } frame_state_t;

  localparam logic [7:0] CRC_INIT = 8'hFF;

  // One byte step of the frame CRC-8 (no reflection, no final XOR).
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] x;
    logic [7:0] n;
    x    = crc ^ data;
    n[0] = x[0] ^ x[3] ^ x[4] ^ x[6];
    n[1] = x[1] ^ x[4] ^ x[5] ^ x[7];
    n[2] = x[2] ^ x[5] ^ x[6];
    n[3] = x[3] ^ x[6] ^ x[7];
    n[4] = x[0] ^ x[3] ^ x[6] ^ x[7];
    n[5] = x[0] ^ x[1] ^ x[3] ^ x[6] ^ x[7];
    n[6] = x[1] ^ x[2] ^ x[4] ^ x[7];
    n[7] = x[2] ^ x[3] ^ x[5];
    return n;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port, one combinational read port. Sequencing lives in the framer FSM.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [0:DEPTH-1];

  // Store each accepted payload byte; contents need no reset since len gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The read is looked up one byte ahead and captured in the framer output register.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_frame_tx.sv
// Frame packetiser: buffers one payload, then emits [SOF][LEN][payload][CRC8] to the UART TX core.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       trunc
);

  localparam int         AW       = $clog2(MAX_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAX_LEN - 1);

  frame_state_t  state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    crc_reg, crc_next;
  logic [7:0]    m_data_reg, m_data_next;
  logic          buf_we;
  logic          trunc_c;
  logic [AW-1:0] buf_rd_ptr;
  logic [7:0]    buf_rd_data;
  logic [7:0]    crc_step;

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (s_data),
    .rd_ptr  (buf_rd_ptr),
    .rd_data (buf_rd_data)
  );

  // Address of the byte that goes on the output after the current one is accepted.
  assign buf_rd_ptr = (state_reg == ST_LEN) ? '0 : rd_ptr_reg + 1'b1;

  // CRC advances over whatever byte is currently presented (LEN or payload).
  assign crc_step = crc8_next(crc_reg, m_data_reg);

  // Next-state logic; output register is loaded with the next frame byte on each transfer.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    len_next    = len_reg;
    crc_next    = crc_reg;
    m_data_next = m_data_reg;
    buf_we      = 1'b0;
    trunc_c     = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        if (s_valid) begin
          buf_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (s_last || (wr_ptr_reg == LAST_IDX)) begin
            len_next    = 8'(wr_ptr_reg) + 8'd1;
            crc_next    = CRC_INIT;
            m_data_next = SOF;
            state_next  = ST_SOF;
            trunc_c     = ~s_last;
          end
        end
      end
      ST_SOF: begin
        if (m_ready) begin
          m_data_next = len_reg;
          state_next  = ST_LEN;
        end
      end
      ST_LEN: begin
        if (m_ready) begin
          crc_next    = crc_step;
          rd_ptr_next = '0;
          m_data_next = buf_rd_data;
          state_next  = ST_PAY;
        end
      end
      ST_PAY: begin
        if (m_ready) begin
          crc_next = crc_step;
          if (8'(rd_ptr_reg) == len_reg - 8'd1) begin
            m_data_next = crc_step;
            state_next  = ST_CRC;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            m_data_next = buf_rd_data;
          end
        end
      end
      ST_CRC: begin
        if (m_ready) begin
          wr_ptr_next = '0;
          m_data_next = 8'h00;
          state_next  = ST_COLLECT;
        end
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  // State, pointer, length, CRC and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_COLLECT;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      len_reg    <= 8'h00;
      crc_reg    <= CRC_INIT;
      m_data_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      len_reg    <= len_next;
      crc_reg    <= crc_next;
      m_data_reg <= m_data_next;
    end
  end

  assign s_ready = (state_reg == ST_COLLECT);
  assign busy    = ~s_ready;
  assign m_valid = busy;
  assign m_data  = m_data_reg;
  assign trunc   = trunc_c;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: fixed frames, forced close, backpressure, mid-frame reset.
module tb_uart_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       busy;
  logic       trunc;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   low_cnt;
  bq_t  rx_q;
  bq_t  ref_q;
  bq_t  pay;
  logic tr;

  always #5 clk = ~clk;

  uart_frame_tx #(.MAX_LEN(16), .SOF(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .trunc   (trunc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC step written as parity over per-bit tap masks.
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
    logic [63:0] taps;
    logic [7:0]  x;
    logic [7:0]  r;
    taps = {8'h2C, 8'h96, 8'hCB, 8'hC9, 8'hC8, 8'h64, 8'hB2, 8'h59};
    x = c ^ d;
    for (int i = 0; i < 8; i++) r[i] = ^(x & taps[8*i +: 8]);
    return r;
  endfunction

  function automatic bq_t mk_frame(input bq_t p);
    bq_t        f;
    logic [7:0] c;
    logic [7:0] l;
    l = 8'(p.size());
    c = crc_model(8'hFF, l);
    f.push_back(8'hA5);
    f.push_back(l);
    foreach (p[i]) begin
      f.push_back(p[i]);
      c = crc_model(c, p[i]);
    end
    f.push_back(c);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last, output logic tr_o);
    int guard = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) chk("send_timeout", 32'(guard), 32'd0);
    tr_o = trunc;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input bq_t p);
    logic t;
    foreach (p[i]) send_byte(p[i], (i == p.size() - 1), t);
  endtask

  task automatic recv(input int n, input bit bp);
    int         got = 0;
    int         guard = 0;
    bit         held = 0;
    logic [7:0] held_d = 8'h00;
    rx_q.delete();
    low_cnt = 0;
    while (got < n && guard < 2000) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_ready) low_cnt++;
      if (held) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(held_d));
      end
      if (m_valid) begin
        if (m_ready) begin
          rx_q.push_back(m_data);
          $display("[%0t] tx byte %0d = %02h", $time, got, m_data);
          got++;
          held = 0;
        end else begin
          held   = 1;
          held_d = m_data;
        end
      end
      tick();
      guard++;
    end
    m_ready = 1'b1;
    if (guard >= 2000) chk("recv_timeout", 32'(got), 32'(n));
  endtask

  task automatic check_frame(input string tag, input bq_t exp);
    chk({tag, "_size"}, 32'(rx_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < rx_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single 00 byte
    send_byte(8'h00, 1'b1, tr);
    chk("t1_trunc", 32'(tr), 32'd0);
    chk("t1_latency", 32'(m_valid), 32'd1);
    recv(4, 0);
    check_frame("t1", '{8'hA5, 8'h01, 8'h00, 8'h75});
    chk("t1_ready_low", 32'(low_cnt), 32'd4);
    chk("t1_ready_after", 32'(s_ready), 32'd1);

    // 2: single FF byte
    send_frame('{8'hFF});
    recv(4, 0);
    check_frame("t2", '{8'hA5, 8'h01, 8'hFF, 8'hD9});

    // 3: 20 bytes, forced close at 16 then a 4-byte frame
    pay.delete();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0, tr);
      chk($sformatf("t3_trunc_%0d", i), 32'(tr), (i == 15) ? 32'd1 : 32'd0);
      pay.push_back(8'(i));
    end
    recv(19, 0);
    check_frame("t3a", mk_frame(pay));
    chk("t3_trunc_idle", 32'(trunc), 32'd0);
    pay = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_frame(pay);
    recv(7, 0);
    check_frame("t3b", mk_frame(pay));

    // 4: backpressure on an 8-byte frame must reproduce the unstalled stream
    pay = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'hE7};
    send_frame(pay);
    recv(11, 0);
    ref_q = rx_q;
    check_frame("t4ref", mk_frame(pay));
    send_frame(pay);
    recv(11, 1);
    check_frame("t4bp", ref_q);

    // 5: reset while in PAY after SOF, LEN and one payload byte went out
    send_frame('{8'h11, 8'h22, 8'h33, 8'h44});
    recv(3, 0);
    m_ready = 1'b0;
    chk("t5_in_pay", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_s_ready", 32'(s_ready), 32'd1);
    #2 rst = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("t5_after_m_valid", 32'(m_valid), 32'd0);
    chk("t5_after_s_ready", 32'(s_ready), 32'd1);
    send_frame('{8'h00});
    recv(4, 0);
    check_frame("t5", '{8'hA5, 8'h01, 8'h00, 8'h75});

    // 6: s_valid held high through emission must not consume bytes
    send_byte(8'h11, 1'b0, tr);
    send_byte(8'h22, 1'b1, tr);
    s_data  = 8'h77;
    s_valid = 1'b1;
    s_last  = 1'b0;
    recv(5, 0);
    check_frame("t6a", mk_frame('{8'h11, 8'h22}));
    send_byte(8'h77, 1'b0, tr);
    send_byte(8'h88, 1'b1, tr);
    recv(5, 0);
    check_frame("t6b", mk_frame('{8'h77, 8'h88}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
